pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage of the RV32I core, directly downstream of the branch comparator.
- Consumes the comparator's taken flag plus jump controls to compute the next PC.
- Fetches instructions from instruction memory over a request/grant/response handshake, then holds each instruction for the core until it is acknowledged.
- Holds the architectural PC register.

---
 rtl/pc_fetch_unit.sv | 130 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: computes the next PC from branch/jump
// controls, fetches over a req/gnt/rvalid handshake and holds each instruction until acked.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | just out of reset, request goes out next cycle
// FETCH    | imem_req high at pc, waiting for imem_gnt
// WAIT_RSP | request accepted, waiting for imem_rvalid
// ISSUE    | instr/pc presented to the core until acked without stall
// HALT     | misaligned target seen, frozen until reset
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_en,
  input  logic            br_taken,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            stall,
  input  logic            instr_ack,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            trap_misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RSP,
    S_ISSUE,
    S_HALT
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            imem_req_q;
  logic            instr_valid_q;
  logic            trap_q;

  logic [XLEN-1:0] next_target;
  logic            target_aligned;
  logic            advance;

  // JALR beats JAL beats a taken branch; everything wraps modulo 2^XLEN.
  always_comb begin
    next_target = pc_q + XLEN'(4);
    if (jalr) begin
      next_target = (rs1 + imm) & ~XLEN'(1);
    end else if (jal || (br_en && br_taken)) begin
      next_target = pc_q + imm;
    end
  end

  assign target_aligned = (next_target[1:0] == 2'b00);
  assign advance        = (state_q == S_ISSUE) && instr_ack && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (imem_gnt) begin
            state_q    <= S_WAIT_RSP;
            imem_req_q <= 1'b0;
          end
        end
        S_WAIT_RSP: begin
          if (imem_rvalid) begin
            state_q       <= S_ISSUE;
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (advance) begin
            instr_valid_q <= 1'b0;
            if (target_aligned) begin
              pc_q       <= next_target;
              state_q    <= S_FETCH;
              imem_req_q <= 1'b1;
            end else begin
              trap_q  <= 1'b1;
              state_q <= S_HALT;
            end
          end
        end
        S_HALT: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
        default: begin
          state_q       <= S_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req        = imem_req_q;
  assign imem_addr       = pc_q;
  assign instr_valid     = instr_valid_q;
  assign instr           = instr_q;
  assign pc              = pc_q;
  assign pc_plus4        = pc_q + XLEN'(4);
  assign trap_misaligned = trap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed fetch/issue sequences against a small next-PC model,
// with a per-cycle compare process and literal address checks along the way.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_en, br_taken, jal, jalr, stall, instr_ack;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imm, rs1, imem_rdata;
  logic        imem_req, instr_valid, trap_misaligned;
  logic [31:0] imem_addr, instr, pc, pc_plus4;

  int          total = 0;
  int          bad   = 0;
  logic        chk_en = 1'b0;
  logic [31:0] m_pc, m_instr;
  logic        m_trap;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .br_en(br_en), .br_taken(br_taken), .jal(jal), .jalr(jalr),
    .imm(imm), .rs1(rs1), .stall(stall), .instr_ack(instr_ack),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .trap_misaligned(trap_misaligned)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic be, bt, jl, jr,
                                             input logic [31:0] im, r1);
    if (jr) return (r1 + im) & 32'hFFFF_FFFE;
    if (jl) return p + im;
    if (be && bt) return p + im;
    return p + 32'd4;
  endfunction

  // Model variables are updated at the negedge before the edge that should change the DUT.
  always @(posedge clk) begin
    #2;
    if (chk_en && !rst) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("trap", trap_misaligned, m_trap);
      chk("req_valid_excl", imem_req & instr_valid, 0);
      if (imem_req) chk("fetch_addr", imem_addr, m_pc);
      if (instr_valid) chk("instr", instr, m_instr);
      if (m_trap) begin
        chk("halt_req", imem_req, 0);
        chk("halt_valid", instr_valid, 0);
      end
    end
  end

  task automatic fetch(input int gdel, input logic junk, input logic [31:0] data);
    int n;
    logic [31:0] a0;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", imem_req, 1);
    a0 = imem_addr;
    for (int i = 0; i < gdel; i++) begin
      imem_rvalid = junk;
      imem_rdata  = 32'hBAD0_0000;
      @(negedge clk);
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, a0);
    end
    imem_gnt    = 1'b1;
    imem_rvalid = junk;
    imem_rdata  = 32'hBAD0_0001;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("req_drop", imem_req, 0);
    chk("valid_wait", instr_valid, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    m_instr     = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("valid_rise", instr_valid, 1);
  endtask

  task automatic issue(input int stall_cyc, input logic be, bt, jl, jr,
                       input logic [31:0] im, r1);
    logic [31:0] tgt;
    chk("issue_valid", instr_valid, 1);
    for (int i = 0; i < stall_cyc; i++) begin
      stall     = 1'b1;
      instr_ack = 1'b1;
      @(negedge clk);
      chk("stall_valid", instr_valid, 1);
      chk("stall_pc", pc, m_pc);
      chk("stall_instr", instr, m_instr);
      chk("stall_noreq", imem_req, 0);
    end
    stall = 1'b0; instr_ack = 1'b1;
    br_en = be; br_taken = bt; jal = jl; jalr = jr; imm = im; rs1 = r1;
    tgt = model_next(m_pc, be, bt, jl, jr, im, r1);
    if (tgt[1:0] == 2'b00) m_pc = tgt;
    else m_trap = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0; br_en = 1'b0; br_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    imm = '0; rs1 = '0;
    chk("ack_valid_drop", instr_valid, 0);
    chk("ack_req", imem_req, !m_trap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    br_en = 0; br_taken = 0; jal = 0; jalr = 0; stall = 0; instr_ack = 0;
    imm = '0; rs1 = '0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    m_pc = 32'h100; m_instr = '0; m_trap = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h100);
    chk("rst_pc4", pc_plus4, 32'h104);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_trap", trap_misaligned, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h100);

    fetch(0, 0, 32'h0000_0013);
    chk("lit_instr", instr, 32'h13);
    chk("lit_pc", pc, 32'h100);
    issue(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("lit_seq", imem_addr, 32'h104);

    fetch(0, 0, 32'h0000_006f);
    issue(0, 0, 0, 1, 0, 32'hFC, 32'h0);
    chk("lit_jal", imem_addr, 32'h200);

    fetch(0, 0, 32'h0000_0063);
    issue(0, 1, 1, 0, 0, 32'hFFFF_FFF8, 32'h0);
    chk("lit_br_taken", imem_addr, 32'h1F8);

    fetch(0, 0, 32'h0000_006f);
    issue(0, 0, 0, 1, 0, 32'h8, 32'h0);
    chk("lit_back_200", imem_addr, 32'h200);

    fetch(0, 0, 32'h0000_0063);
    issue(0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0);
    chk("lit_br_not", imem_addr, 32'h204);

    fetch(0, 0, 32'h0000_0013);
    issue(0, 0, 1, 0, 0, 32'h40, 32'h0);
    chk("lit_br_en0", imem_addr, 32'h208);

    fetch(0, 0, 32'h0000_006f);
    issue(0, 0, 0, 1, 0, 32'hF8, 32'h0);
    chk("lit_to_300", imem_addr, 32'h300);

    fetch(0, 0, 32'h0000_0067);
    chk("lit_pc4_300", pc_plus4, 32'h304);
    issue(0, 0, 0, 1, 1, 32'h3, 32'h1001);
    chk("lit_jalr", imem_addr, 32'h1004);

    // gnt withheld with stray rvalid, then a stalled ack
    fetch(3, 1, 32'h0000_0067);
    chk("lit_junk_ignored", instr, 32'h67);
    issue(2, 0, 0, 0, 1, 32'hC, 32'hFFFF_FFF0);
    chk("lit_jalr_top", imem_addr, 32'hFFFF_FFFC);

    fetch(0, 0, 32'h0000_0013);
    chk("lit_wrap_pc4", pc_plus4, 32'h0);
    issue(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("lit_wrap", imem_addr, 32'h0);

    fetch(0, 0, 32'h0000_006f);
    issue(0, 0, 0, 1, 0, 32'h400, 32'h0);
    chk("lit_to_400", imem_addr, 32'h400);

    fetch(0, 0, 32'h0000_006f);
    issue(0, 0, 0, 1, 0, 32'h2, 32'h0);
    chk("lit_trap", trap_misaligned, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_noreq", imem_req, 0);
      chk("halt_pc", pc, 32'h400);
      chk("halt_trap", trap_misaligned, 1);
    end

    rst = 1'b1;
    m_pc = 32'h100; m_instr = '0; m_trap = 1'b0;
    #1;
    chk("halt_rst_trap", trap_misaligned, 0);
    @(negedge clk);
    rst = 1'b0;
    fetch(0, 0, 32'h0000_0055);
    issue(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("lit_seq2", imem_addr, 32'h104);

    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("wait_noreq", imem_req, 0);
    #2;
    rst = 1'b1;
    m_pc = 32'h100; m_instr = '0;
    #1;
    chk("async_pc", pc, 32'h100);
    chk("async_instr", instr, 32'h0);
    chk("async_req", imem_req, 0);
    chk("async_valid", instr_valid, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("late_rsp_valid", instr_valid, 0);
    chk("late_rsp_req", imem_req, 1);
    fetch(1, 0, 32'h0000_0077);
    chk("lit_after_rst", instr, 32'h77);
    chk("lit_after_rst_pc", pc, 32'h100);
    issue(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("lit_seq3", imem_addr, 32'h104);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
